// File: rtl/mux2x1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux2x1_rr_arbiter
// Description : Round-robin front-end for the 2:1 conditional mux datapath.
//               Merges two valid/ready source streams (A, B) into a one-entry
//               output register. The register carries the granted word and a
//               registered select (0 = A, 1 = B). A new word can be loaded in
//               the same cycle the held word drains, so the merge sustains one
//               word per cycle. When both sources are valid, the grant goes to
//               the source that was not granted last.
//               Optional grant counters are enabled by the macro
//               MUX2X1_RR_ARBITER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2x1_rr_arbiter #(
  parameter int DATA_W = 8
`ifdef MUX2X1_RR_ARBITER_STATS_EN
  ,parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sel,
  input  logic              out_ready
`ifdef MUX2X1_RR_ARBITER_STATS_EN
  ,input  logic             cnt_clr,
  output logic [CNT_W-1:0]  grant_cnt_a,
  output logic [CNT_W-1:0]  grant_cnt_b
`endif
);

  localparam logic c_sel_a = 1'b0;
  localparam logic c_sel_b = 1'b1;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_sel;
  logic              r_last_sel;

  logic              w_load;
  logic              w_any_valid;
  logic              w_pick;
  logic              w_grant;

  // The register can take a word when it is empty or its word leaves this cycle.
  assign w_load      = ~r_out_valid | out_ready;
  assign w_any_valid = a_valid | b_valid;

  // A lone requester wins outright; a tie goes to the side not granted last.
  assign w_pick  = (a_valid & b_valid) ? ~r_last_sel : b_valid;
  assign w_grant = w_load & w_any_valid;

  // rst_n gates the readies so no source sees an accept while reset is held,
  // even though the empty register would otherwise report a load.
  assign a_ready = rst_n & w_grant & a_valid & (w_pick == c_sel_a);
  assign b_ready = rst_n & w_grant & b_valid & (w_pick == c_sel_b);

  // Output register and round-robin pointer; hold when full and stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= c_sel_a;
      r_last_sel  <= c_sel_b;
    end else if (w_load) begin
      if (w_any_valid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= (w_pick == c_sel_b) ? b_data : a_data;
        r_out_sel   <= w_pick;
        r_last_sel  <= w_pick;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

`ifdef MUX2X1_RR_ARBITER_STATS_EN
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;

  // Saturating per-source grant counters; a clear wins over a same-cycle grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (cnt_clr) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (a_ready && a_valid && !(&r_cnt_a)) begin
        r_cnt_a <= r_cnt_a + 1'b1;
      end
      if (b_ready && b_valid && !(&r_cnt_b)) begin
        r_cnt_b <= r_cnt_b + 1'b1;
      end
    end
  end

  assign grant_cnt_a = r_cnt_a;
  assign grant_cnt_b = r_cnt_b;
`endif

endmodule
`default_nettype wire
